// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: pipeline-side request/response bundle for mem_arbiter.
//   fetch_* : read-only fetch port (F)  -- req/addr in, done/data/stall out
//   data_*  : read/write memory port (D) -- req/wr/addr/in in, done/out/stall out
// Modports: slave  = arbiter side (mem_arbiter)
//           master = pipeline side (requesters / testbench)
interface mem_arbiter_if;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;

  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_done;
  logic [DW-1:0] fetch_data;
  logic          fetch_stall;

  logic          data_req;
  logic          data_wr;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_in;
  logic          data_done;
  logic [DW-1:0] data_out;
  logic          data_stall;

  modport slave (
    input  fetch_req, fetch_addr,
    output fetch_done, fetch_data, fetch_stall,
    input  data_req, data_wr, data_addr, data_in,
    output data_done, data_out, data_stall
  );

  modport master (
    output fetch_req, fetch_addr,
    input  fetch_done, fetch_data, fetch_stall,
    output data_req, data_wr, data_addr, data_in,
    input  data_done, data_out, data_stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 16-bit memory (combinational read,
// write on clock edge when enable&wr) between a fetch port F (read-only) and
// a data port D (read/write). Each access is sequenced IDLE -> ACCESS -> DONE,
// with WAIT_CYCLES extra cycles spent in ACCESS before the memory is enabled.
// D has priority; F is forced after STARVE_LIMIT consecutive D grants while
// F waits.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   bus (slave)      fetch_* / data_* request/response bundle
//   createdump       dump request; forwarded as mem_createdump while IDLE
//   mem_enable/mem_wr/mem_addr/mem_data_in  to memory macro
//   mem_data_out     from memory macro
//   mem_createdump   to memory macro
//   busy             FSM not in IDLE
// Optional (macro MEM_ARB_STATS_EN):
//   stat_fetch_grants, stat_data_grants, stat_conflicts  saturating counters
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus,
  input  logic         createdump,
  output logic         mem_enable,
  output logic         mem_wr,
  output logic [15:0]  mem_addr,
  output logic [15:0]  mem_data_in,
  input  logic [15:0]  mem_data_out,
  output logic         mem_createdump,
  output logic         busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]  stat_fetch_grants,
  output logic [15:0]  stat_data_grants,
  output logic [15:0]  stat_conflicts
`endif
);

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_t        state_q;
  logic          owner_d_q;     // 1: current access belongs to D, 0: F
  req_t          req_q;
  logic [CW-1:0] wait_q;
  logic [CW-1:0] starve_q;
  logic          fetch_done_q;
  logic          data_done_q;
  logic [DW-1:0] fetch_data_q;
  logic [DW-1:0] data_out_q;

  logic          grant_d;
  logic          pick_data_d;
  logic          starved_d;
  logic          conflict_d;

  // Arbitration decision for the current IDLE cycle; dump requests block grants
  always_comb begin
    starved_d   = bus.fetch_req && (starve_q >= CW'(STARVE_LIMIT));
    pick_data_d = bus.data_req && !starved_d;
    grant_d     = (state_q == S_IDLE) && !createdump && (bus.fetch_req || bus.data_req);
    conflict_d  = grant_d && bus.fetch_req && bus.data_req;
  end

  // Access sequencer, arbitration state and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_d_q    <= 1'b0;
      req_q        <= '0;
      wait_q       <= '0;
      starve_q     <= '0;
      fetch_done_q <= 1'b0;
      data_done_q  <= 1'b0;
      fetch_data_q <= '0;
      data_out_q   <= '0;
    end else begin
      fetch_done_q <= 1'b0;
      data_done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          // Starve counter only tracks D grants made while F is waiting
          if (!bus.fetch_req) begin
            starve_q <= '0;
          end else if (grant_d) begin
            if (pick_data_d) begin
              if (starve_q != {CW{1'b1}}) starve_q <= starve_q + CW'(1);
            end else begin
              starve_q <= '0;
            end
          end
          if (grant_d) begin
            owner_d_q <= pick_data_d;
            if (pick_data_d) begin
              req_q <= '{wr: bus.data_wr, addr: bus.data_addr, wdata: bus.data_in};
            end else begin
              req_q <= '{wr: 1'b0, addr: bus.fetch_addr, wdata: '0};
            end
            wait_q  <= CW'(WAIT_CYCLES);
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (wait_q == '0) begin
            // Memory is enabled this cycle; capture read data on this edge
            if (owner_d_q) begin
              if (!req_q.wr) data_out_q <= mem_data_out;
              data_done_q <= 1'b1;
            end else begin
              fetch_data_q <= mem_data_out;
              fetch_done_q <= 1'b1;
            end
            state_q <= S_DONE;
          end else begin
            wait_q <= wait_q - CW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_fetch_q;
  logic [15:0] stat_data_q;
  logic [15:0] stat_conf_q;

  // Saturating grant / conflict counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetch_q <= '0;
      stat_data_q  <= '0;
      stat_conf_q  <= '0;
    end else if (grant_d) begin
      if (pick_data_d) begin
        if (stat_data_q != 16'hFFFF) stat_data_q <= stat_data_q + 16'd1;
      end else begin
        if (stat_fetch_q != 16'hFFFF) stat_fetch_q <= stat_fetch_q + 16'd1;
      end
      if (conflict_d && (stat_conf_q != 16'hFFFF)) stat_conf_q <= stat_conf_q + 16'd1;
    end
  end

  assign stat_fetch_grants = stat_fetch_q;
  assign stat_data_grants  = stat_data_q;
  assign stat_conflicts    = stat_conf_q;
`else
  logic unused_conflict;
  assign unused_conflict = conflict_d;
`endif

  // Memory strobes are gated by rst so an access caught by reset never commits
  always_comb begin
    mem_enable     = !rst && (state_q == S_ACCESS) && (wait_q == '0);
    mem_wr         = mem_enable && req_q.wr;
    mem_addr       = (state_q == S_ACCESS) ? req_q.addr  : '0;
    mem_data_in    = (state_q == S_ACCESS) ? req_q.wdata : '0;
    mem_createdump = !rst && (state_q == S_IDLE) && createdump;
    busy           = (state_q != S_IDLE);
  end

  assign bus.fetch_done  = fetch_done_q;
  assign bus.fetch_data  = fetch_data_q;
  assign bus.fetch_stall = bus.fetch_req & ~fetch_done_q;
  assign bus.data_done   = data_done_q;
  assign bus.data_out    = data_out_q;
  assign bus.data_stall  = bus.data_req & ~data_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
// (WAIT_CYCLES=1, STARVE_LIMIT=3) with a behavioural memory2c-style memory.
// Inputs change 1ns after posedge; outputs are checked on the negedge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        createdump;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        mem_createdump;
  logic        busy;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_fetch_grants;
  logic [15:0] stat_data_grants;
  logic [15:0] stat_conflicts;
`endif

  int vectors    = 0;
  int miscompares = 0;

  logic [15:0] mem [0:65535];

  mem_arbiter_if bus ();

  mem_arbiter #(
    .WAIT_CYCLES (1),
    .STARVE_LIMIT(3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .createdump    (createdump),
    .mem_enable    (mem_enable),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_data_in   (mem_data_in),
    .mem_data_out  (mem_data_out),
    .mem_createdump(mem_createdump),
    .busy          (busy)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_fetch_grants(stat_fetch_grants),
    .stat_data_grants (stat_data_grants),
    .stat_conflicts   (stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  // memory2c-style model: combinational read, write on edge when enable&wr
  assign mem_data_out = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_enable && mem_wr) mem[mem_addr] <= mem_data_in;
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] <= 16'h0000;
    mem[16'h0040] <= 16'h1234;
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  // Runs one D access to completion; reports latency and write strobes seen
  task automatic data_access(input logic wr, input logic [15:0] addr, input logic [15:0] din,
                             output bit ok, output int lat, output int wen);
    ok  = 1'b0;
    lat = -1;
    wen = 0;
    bus.data_req  = 1'b1;
    bus.data_wr   = wr;
    bus.data_addr = addr;
    bus.data_in   = din;
    for (int c = 0; c < 20; c++) begin
      mid;
      if (mem_enable && mem_wr) wen++;
      if (bus.data_done) begin
        ok  = 1'b1;
        lat = c;
        break;
      end
      next_cycle;
    end
    next_cycle;
    bus.data_req = 1'b0;
    bus.data_wr  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    next_cycle;
    next_cycle;
    mid;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    vectors++;
    if ({bus.fetch_done, bus.data_done} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_done: got %b%b expected 00", bus.fetch_done, bus.data_done);
    end
    vectors++;
    if ({bus.fetch_data, bus.data_out} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h/%h expected 0000/0000", bus.fetch_data, bus.data_out);
    end
    vectors++;
    if ({mem_enable, mem_wr, mem_createdump} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_mem_strobes: got %b%b%b expected 000", mem_enable, mem_wr, mem_createdump);
    end
    next_cycle;
    rst = 1'b0;
  endtask

  task automatic test_fetch_read;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 16'h0040;
    for (int c = 0; c < 5; c++) begin
      mid;
      vectors++;
      if (mem_enable !== (c == 2)) begin
        miscompares++;
        $display("FAIL fetch_mem_enable c%0d: got %b expected %b", c, mem_enable, (c == 2));
      end
      vectors++;
      if (bus.fetch_stall !== (c <= 2)) begin
        miscompares++;
        $display("FAIL fetch_stall c%0d: got %b expected %b", c, bus.fetch_stall, (c <= 2));
      end
      vectors++;
      if (bus.fetch_done !== (c == 3)) begin
        miscompares++;
        $display("FAIL fetch_done c%0d: got %b expected %b", c, bus.fetch_done, (c == 3));
      end
      if (c >= 3) begin
        vectors++;
        if (bus.fetch_data !== 16'h1234) begin
          miscompares++;
          $display("FAIL fetch_data c%0d: got %h expected 1234", c, bus.fetch_data);
        end
      end
      if (c == 2) begin
        vectors++;
        if (mem_addr !== 16'h0040) begin
          miscompares++;
          $display("FAIL fetch_mem_addr: got %h expected 0040", mem_addr);
        end
      end
      next_cycle;
      if (c == 3) bus.fetch_req = 1'b0;
    end
  endtask

  task automatic test_write_read;
    bit ok;
    int lat;
    int wen;
    data_access(1'b1, 16'h0100, 16'hBEEF, ok, lat, wen);
    vectors++;
    if (!ok || lat != 3) begin
      miscompares++;
      $display("FAIL write_latency: got ok=%0d lat=%0d expected ok=1 lat=3", ok, lat);
    end
    vectors++;
    if (wen != 1) begin
      miscompares++;
      $display("FAIL write_strobes: got %0d expected 1", wen);
    end
    vectors++;
    if (bus.data_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL write_data_out: got %h expected 0000", bus.data_out);
    end
    vectors++;
    if (mem[16'h0100] !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL write_mem: got %h expected beef", mem[16'h0100]);
    end
    data_access(1'b0, 16'h0100, 16'h0000, ok, lat, wen);
    vectors++;
    if (!ok || wen != 0) begin
      miscompares++;
      $display("FAIL read_done: got ok=%0d wen=%0d expected ok=1 wen=0", ok, wen);
    end
    vectors++;
    if (bus.data_out !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL read_data_out: got %h expected beef", bus.data_out);
    end
    vectors++;
    if (bus.fetch_data !== 16'h1234) begin
      miscompares++;
      $display("FAIL read_fetch_hold: got %h expected 1234", bus.fetch_data);
    end
  endtask

  task automatic test_arbitration;
    string expected_order;
    string got;
    // Fresh counters so the grant statistics cover only this scenario
    rst = 1'b1;
    next_cycle;
    rst = 1'b0;
    expected_order = "DDDFDDDF";
    got = "";
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 16'h0040;
    bus.data_req   = 1'b1;
    bus.data_wr    = 1'b0;
    bus.data_addr  = 16'h0100;
    for (int c = 0; c < 60 && got.len() < 8; c++) begin
      mid;
      if (bus.fetch_done && bus.data_done) got = {got, "X"};
      else if (bus.fetch_done) got = {got, "F"};
      else if (bus.data_done) got = {got, "D"};
      next_cycle;
    end
    bus.fetch_req = 1'b0;
    bus.data_req  = 1'b0;
    vectors++;
    if (got.len() != 8) begin
      miscompares++;
      $display("FAIL arb_grant_count: got %0d grants (%s) expected 8", got.len(), got);
    end
    for (int i = 0; i < 8 && i < got.len(); i++) begin
      vectors++;
      if (got[i] != expected_order[i]) begin
        miscompares++;
        $display("FAIL arb_order[%0d]: got %s expected %s", i, got, expected_order);
      end
    end
    vectors++;
    if (bus.fetch_data !== 16'h1234 || bus.data_out !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL arb_data: got %h/%h expected 1234/beef", bus.fetch_data, bus.data_out);
    end
`ifdef MEM_ARB_STATS_EN
    vectors++;
    if (stat_data_grants !== 16'd6 || stat_fetch_grants !== 16'd2 || stat_conflicts !== 16'd8) begin
      miscompares++;
      $display("FAIL arb_stats: got d=%0d f=%0d c=%0d expected d=6 f=2 c=8",
               stat_data_grants, stat_fetch_grants, stat_conflicts);
    end
`endif
  endtask

  task automatic test_createdump;
    bus.data_req  = 1'b1;
    bus.data_wr   = 1'b0;
    bus.data_addr = 16'h0100;
    createdump    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      mid;
      vectors++;
      if (mem_createdump !== 1'b1 || busy !== 1'b0 || mem_enable !== 1'b0) begin
        miscompares++;
        $display("FAIL dump_hold c%0d: got dump=%b busy=%b en=%b expected 1/0/0",
                 c, mem_createdump, busy, mem_enable);
      end
      next_cycle;
    end
    createdump = 1'b0;
    mid;
    vectors++;
    if (mem_createdump !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL dump_release: got dump=%b busy=%b expected 0/0", mem_createdump, busy);
    end
    next_cycle;
    mid;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL dump_grant: got busy=%b expected 1", busy);
    end
    next_cycle;
    mid;
    vectors++;
    if (bus.data_done !== 1'b0) begin
      miscompares++;
      $display("FAIL dump_early_done: got %b expected 0", bus.data_done);
    end
    next_cycle;
    mid;
    vectors++;
    if (bus.data_done !== 1'b1 || bus.data_out !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL dump_done: got done=%b data=%h expected 1/beef", bus.data_done, bus.data_out);
    end
    next_cycle;
    bus.data_req = 1'b0;
  endtask

  task automatic test_reset_abort;
    bit ok;
    int lat;
    int wen;
    bus.data_req  = 1'b1;
    bus.data_wr   = 1'b1;
    bus.data_addr = 16'h0200;
    bus.data_in   = 16'h5555;
    mid;
    next_cycle;
    mid;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_busy_before: got %b expected 1", busy);
    end
    next_cycle;
    rst = 1'b1;
    bus.data_req = 1'b0;
    bus.data_wr  = 1'b0;
    mid;
    vectors++;
    if (mem_enable !== 1'b0 || mem_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_enable: got en=%b wr=%b expected 0/0", mem_enable, mem_wr);
    end
    next_cycle;
    rst = 1'b0;
    mid;
    vectors++;
    if (busy !== 1'b0 || bus.data_done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: got busy=%b done=%b expected 0/0", busy, bus.data_done);
    end
    vectors++;
    if (mem[16'h0200] !== 16'h0000) begin
      miscompares++;
      $display("FAIL abort_mem: got %h expected 0000", mem[16'h0200]);
    end
    next_cycle;
    mid;
    vectors++;
    if (bus.data_done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %b expected 0", bus.data_done);
    end
    next_cycle;
    data_access(1'b0, 16'h0200, 16'h0000, ok, lat, wen);
    vectors++;
    if (!ok || bus.data_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL abort_readback: got ok=%0d data=%h expected 1/0000", ok, bus.data_out);
    end
  endtask

  initial begin
    rst            = 1'b1;
    createdump     = 1'b0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = 16'h0000;
    bus.data_req   = 1'b0;
    bus.data_wr    = 1'b0;
    bus.data_addr  = 16'h0000;
    bus.data_in    = 16'h0000;
    test_reset;
    test_fetch_read;
    test_write_read;
    test_createdump;
    test_arbitration;
    test_reset_abort;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port 16-bit data memory between the fetch stage (read-only port F) and the memory stage (read/write port D).
- The memory is a memory2c-style macro: combinational read; write commits at the clock edge when enable&wr.
- Sequences each access through a small FSM that models a configurable memory wait time.
- Returns per-port done pulses and stall levels to the pipeline.

Parameters:
- WAIT_CYCLES, 1, extra cycles each access occupies before the memory is enabled (0..15).
- STARVE_LIMIT, 3, consecutive D grants allowed while F waits before F is forced (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- fetch_req  in  1  F request level; held until fetch_done
- fetch_addr  in  16  F address
- fetch_done  out  1  one-cycle pulse; fetch_data valid
- fetch_data  out  16  F read data; holds until next F completion
- fetch_stall  out  1  fetch_req & ~fetch_done
- data_req  in  1  D request level; held until data_done
- data_wr  in  1  D write (1) / read (0)
- data_addr  in  16  D address
- data_in  in  16  D write data
- data_done  out  1  one-cycle pulse
- data_out  out  16  D read data; holds until next D read completion
- data_stall  out  1  data_req & ~data_done
- createdump  in  1  dump request from halt logic
- mem_enable  out  1  to memory enable
- mem_wr  out  1  to memory wr
- mem_addr  out  16  to memory addr
- mem_data_in  out  16  to memory data_in
- mem_data_out  in  16  from memory data_out
- mem_createdump  out  1  to memory createdump
- busy  out  1  FSM not in IDLE

Behaviour:
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If createdump=1: assert mem_createdump; grant nothing this cycle.
  - Otherwise, if any request: pick owner; latch addr/wr/wdata; load wait counter = WAIT_CYCLES; go to ACCESS.
- ACCESS:
  - Counter decrements each cycle.
  - In the cycle where counter==0: mem_enable=1, and mem_wr = latched wr.
  - On that edge: a read latches mem_data_out into the owner's data register, then go to DONE.
  - mem_enable and mem_wr are 0 in all other cycles and states.
  - mem_addr and mem_data_in drive the latched values throughout ACCESS; they are 0 elsewhere.
- DONE: owner's done = 1 for exactly one cycle; then go to IDLE.
- Latency: request seen in IDLE at cycle t gives done at cycle t+WAIT_CYCLES+2. Back-to-back grants are possible every WAIT_CYCLES+3 cycles.
- Requesters drop req on the edge where done is high. A req still high in the following IDLE cycle is treated as a new request.
- Request inputs are sampled only in IDLE. Changes to addr/wdata/wr after grant are ignored.
- Arbitration:
  - D has priority over F.
  - Starve counter (4 bits) increments on each D grant made while fetch_req=1.
  - When the counter reaches STARVE_LIMIT and both ports request, F is granted.
  - Counter clears on any F grant, and in IDLE whenever fetch_req=0.
- Simultaneous createdump and requests: dump wins; requests wait until createdump is deasserted.
- D write completion pulses data_done and leaves data_out unchanged.
- Reset (rst=1):
  - While asserted, mem_enable, mem_wr and mem_createdump are forced to 0, including mid-ACCESS; no write commits in a reset cycle.
  - Next state: IDLE, starve counter 0, wait counter 0.
  - fetch_done=0, data_done=0, fetch_data=0, data_out=0, busy=0.
  - An aborted access produces no done pulse; requesters re-issue.
- Address arithmetic: none; addresses pass through unmodified, full 16-bit.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined: adds outputs stat_fetch_grants[15:0], stat_data_grants[15:0] and stat_conflicts[15:0].
  - stat_conflicts counts IDLE cycles where both ports request and a grant is made.
  - All three counters saturate at 16'hFFFF and clear on rst.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- WAIT_CYCLES=1, F read at 0x0040 (memory holds 0x1234) at cycle 0 -> mem_enable exactly one cycle at cycle 2; fetch_done at cycle 3 with fetch_data=0x1234; fetch_stall high cycles 0-2.
- D write 0xBEEF to 0x0100, then D read 0x0100 -> one mem_enable&mem_wr cycle; second data_done with data_out=0xBEEF; fetch_data unchanged.
- Both ports requesting continuously, D re-requesting after each done, STARVE_LIMIT=3 -> grant order D,D,D,F,D,D,D,F.
- createdump=1 in IDLE while data_req=1 -> mem_createdump=1 and no grant; grant occurs in the first IDLE cycle after createdump drops.
- rst pulsed during the enable cycle of a D write to 0x0200 (old value 0x0000) -> mem_enable=0 that cycle, no data_done; 0x0200 still reads 0x0000; FSM in IDLE.
- MEM_ARB_STATS_EN defined, after the arbitration scenario over 8 grants -> stat_data_grants=6, stat_fetch_grants=2, stat_conflicts=8.
